// File: rtl/sobel_linebuf.sv
// 3x3 Sobel neighbourhood generator built from two line buffers.
// Optional eof output when SOBEL_LINEBUF_EOF_EN is defined.
module sobel_linebuf #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] p0,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
`ifdef SOBEL_LINEBUF_EOF_EN
  output logic       eof,
`endif
  output logic       win_valid
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col, cur_c, nxt_c;
  logic [RW-1:0] row, cur_r, nxt_r;
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb2 [IMG_W];
  logic [7:0]    up1, up2, ctr;
  logic          last_c, last_r, inwin;

  // Position of the incoming pixel; sof forces it to (0,0).
  always_comb begin
    cur_c  = sof ? '0 : col;
    cur_r  = sof ? '0 : row;
    up1    = lb1[cur_c];
    up2    = lb2[cur_c];
    last_c = (cur_c == CW'(IMG_W - 1));
    last_r = (cur_r == RW'(IMG_H - 1));
    nxt_c  = last_c ? '0 : cur_c + CW'(1);
    nxt_r  = cur_r;
    if (last_c)
      nxt_r = last_r ? '0 : cur_r + RW'(1);
    inwin  = (cur_r >= RW'(2)) && (cur_c >= CW'(2));
  end

  // Line buffers: r-1 line moves to r-2 as the new pixel lands.
  always_ff @(posedge clk) begin
    if (!rst && pix_valid) begin
      lb2[cur_c] <= up1;
      lb1[cur_c] <= pix_in;
    end
  end

  // Counters and the shifting 3x3 window (outputs are the window).
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      p0        <= '0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
      ctr       <= '0;
      p5        <= '0;
      p6        <= '0;
      p7        <= '0;
      p8        <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (pix_valid) begin
        col       <= nxt_c;
        row       <= nxt_r;
        p0        <= p1;
        p1        <= p2;
        p2        <= up2;
        p3        <= ctr;
        ctr       <= p5;
        p5        <= up1;
        p6        <= p7;
        p7        <= p8;
        p8        <= pix_in;
        win_valid <= inwin;
      end
    end
  end

`ifdef SOBEL_LINEBUF_EOF_EN
  // Flags the window centred on the frame's final pixel.
  always_ff @(posedge clk) begin
    if (rst)
      eof <= 1'b0;
    else
      eof <= pix_valid && inwin && last_c && last_r;
  end
`endif

endmodule

// File: tb/tb_sobel_linebuf.sv
// Scoreboard bench for sobel_linebuf: 4x4 and 8x8 instances.
// Expected windows come from an image-array model of sent pixels.
module tb_sobel_linebuf;

  typedef struct packed {
    logic [63:0] w;
    logic        e;
  } win_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix4 = '0, pix8 = '0;
  logic       pv4 = 1'b0, pv8 = 1'b0;
  logic       sf4 = 1'b0, sf8 = 1'b0;

  logic [7:0] a0, a1, a2, a3, a5, a6, a7, a8;
  logic [7:0] b0, b1, b2, b3, b5, b6, b7, b8;
  logic       wva, wvb, ea, eb;

  int checks = 0;
  int errors = 0;

  win_t        q [2][$];
  int          cnt [2];
  logic [63:0] first [2];
  logic [63:0] w37;
  logic        acc [2];
  logic [7:0]  img [2][8][8];
  int          rm [2];
  int          cm [2];

  always #5 clk = ~clk;

  sobel_linebuf #(.IMG_W(4), .IMG_H(4)) ua (
    .clk(clk), .rst(rst), .pix_in(pix4),
    .pix_valid(pv4), .sof(sf4),
    .p0(a0), .p1(a1), .p2(a2), .p3(a3),
    .p5(a5), .p6(a6), .p7(a7), .p8(a8),
`ifdef SOBEL_LINEBUF_EOF_EN
    .eof(ea),
`endif
    .win_valid(wva)
  );

  sobel_linebuf #(.IMG_W(8), .IMG_H(8)) ub (
    .clk(clk), .rst(rst), .pix_in(pix8),
    .pix_valid(pv8), .sof(sf8),
    .p0(b0), .p1(b1), .p2(b2), .p3(b3),
    .p5(b5), .p6(b6), .p7(b7), .p8(b8),
`ifdef SOBEL_LINEBUF_EOF_EN
    .eof(eb),
`endif
    .win_valid(wvb)
  );

`ifndef SOBEL_LINEBUF_EOF_EN
  assign ea = 1'b0;
  assign eb = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic wv,
                     input logic [63:0] w, input logic e);
    win_t x;
    if (!acc[d]) begin
      chk($sformatf("idle_wv%0d", d), 64'(wv), 64'd0);
    end else if (wv) begin
      if (q[d].size() == 0) begin
        chk($sformatf("unexp_win%0d", d), 64'(1), 64'(0));
      end else begin
        x = q[d].pop_front();
        chk($sformatf("win%0d_%0d", d, cnt[d]), w, x.w);
`ifdef SOBEL_LINEBUF_EOF_EN
        chk($sformatf("eof%0d_%0d", d, cnt[d]), 64'(e), 64'(x.e));
`endif
      end
      cnt[d]++;
      if (cnt[d] == 1) first[d] = w;
      if (d == 1 && cnt[d] == 37) w37 = w;
    end
`ifdef SOBEL_LINEBUF_EOF_EN
    if (!wv) chk($sformatf("eof_idle%0d", d), 64'(e), 64'd0);
`endif
  endtask

  always @(posedge clk) begin
    acc[0] <= pv4 & ~rst;
    acc[1] <= pv8 & ~rst;
  end

  always @(negedge clk) begin
    mon(0, wva, {a0, a1, a2, a3, a5, a6, a7, a8}, ea);
    mon(1, wvb, {b0, b1, b2, b3, b5, b6, b7, b8}, eb);
  end

  task automatic send(input int d, input int v, input bit s);
    int   sz, r, c;
    win_t x;
    sz = (d == 0) ? 4 : 8;
    @(posedge clk); #2;
    pv4  = (d == 0);
    pv8  = (d == 1);
    sf4  = (d == 0) && s;
    sf8  = (d == 1) && s;
    pix4 = 8'(v);
    pix8 = 8'(v);
    if (s) begin
      rm[d] = 0;
      cm[d] = 0;
    end
    r = rm[d];
    c = cm[d];
    img[d][r][c] = 8'(v);
    if (r >= 2 && c >= 2) begin
      x.w = {img[d][r-2][c-2], img[d][r-2][c-1], img[d][r-2][c],
             img[d][r-1][c-2], img[d][r-1][c],
             img[d][r][c-2], img[d][r][c-1], img[d][r][c]};
      x.e = (r == sz - 1) && (c == sz - 1);
      q[d].push_back(x);
    end
    cm[d] = c + 1;
    if (cm[d] == sz) begin
      cm[d] = 0;
      rm[d] = (r == sz - 1) ? 0 : r + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      pv4 = 1'b0;
      pv8 = 1'b0;
      sf4 = 1'b0;
      sf8 = 1'b0;
    end
  endtask

  task automatic drain(input int d, input int expn, input string nm);
    idle(2);
    for (int i = 0; i < 10 && q[d].size() != 0; i++) idle(1);
    chk({nm, "_qempty"}, 64'(q[d].size()), 64'd0);
    chk({nm, "_count"}, 64'(cnt[d]), 64'(expn));
    cnt[d] = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_b"}, {b0, b1, b2, b3, b5, b6, b7, b8}, 64'd0);
    chk({nm, "_bwv"}, 64'(wvb), 64'd0);
    chk({nm, "_a"}, {a0, a1, a2, a3, a5, a6, a7, a8}, 64'd0);
    chk({nm, "_awv"}, 64'(wva), 64'd0);
  endtask

  initial begin
    cnt[0] = 0;
    cnt[1] = 0;
    rm = '{0, 0};
    cm = '{0, 0};
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) send(0, i, i == 0);
    drain(0, 4, "f4");
    chk("f4_first", first[0],
        {8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd10});

    for (int i = 0; i < 16; i++) begin
      send(0, i, i == 0);
      idle(1);
    end
    drain(0, 4, "f4gap");
    chk("f4gap_first", first[0],
        {8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd10});

    for (int i = 0; i < 64; i++) send(1, (i * 3) & 255, i == 0);
    for (int i = 0; i < 64; i++) send(1, 255 - i, i == 0);
    drain(1, 72, "f8x2");
    chk("f8_f1_p0", 64'(first[1][63:56]), 64'd0);
    chk("f8_f2_p0", 64'(w37[63:56]), 64'd255);

    for (int i = 0; i < 20; i++) send(1, i + 1, i == 0);
    for (int j = 0; j < 64; j++) begin
      send(1, 100 + j, j == 0);
      if (j == 17) chk("abort_nowin", 64'(cnt[1]), 64'd2);
    end
    drain(1, 38, "abort");

    for (int i = 0; i < 30; i++) send(1, (7 * i) & 255, i == 0);
    drain(1, 10, "pre_rst");
    @(posedge clk); #2;
    rst = 1'b1;
    rm = '{0, 0};
    cm = '{0, 0};
    @(posedge clk); #2;
    chk_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 64; i++) send(1, i ^ 8'h5a, 1'b0);
    drain(1, 36, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_linebuf.md
SOBEL_LINEBUF -- requirements
Module: sobel_linebuf

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per line (range 4..1024).
REQ-002 SHALL have parameter IMG_H, default 64, lines per frame (range 3..1024).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pix_in  input  8  incoming pixel, raster order, unsigned.
REQ-006 SHALL have port pix_valid  input  1  pix_in is accepted on every clk edge where this is high.
REQ-007 SHALL have port sof  input  1  start of frame; qualified by pix_valid; marks pix_in as pixel (row 0, col 0).
REQ-008 SHALL have ports p0,p1,p2,p3,p5,p6,p7,p8  output  8 each  3x3 neighbourhood, center excluded, registered.
REQ-009 SHALL have port win_valid  output  1  p0..p8 form a valid interior window this cycle.

Function
REQ-010 SHALL keep col counter 0..IMG_W-1 and row counter 0..IMG_H-1; both advance only on accepted pixels.
REQ-011 SHALL wrap col from IMG_W-1 to 0 while incrementing row; row wraps from IMG_H-1 to 0 on the last pixel of the frame.
REQ-012 SHALL, on accepted pixel with sof=1, treat that pixel as (0,0) regardless of counter state; next pixel is (0,1).
REQ-013 SHALL hold two line buffers of IMG_W x 8 bits (lines r-1 and r-2), read and written at address col once per accepted pixel.
REQ-014 SHALL hold a 3x3 register window shifted left by one column per accepted pixel; new column = {line r-2[col], line r-1[col], pix_in}.
REQ-015 SHALL map outputs for current pixel (r,c): p0=(r-2,c-2), p1=(r-2,c-1), p2=(r-2,c), p3=(r-1,c-2), p5=(r-1,c), p6=(r,c-2), p7=(r,c-1), p8=(r,c).
REQ-016 SHALL assert win_valid exactly one cycle after an accepted pixel with row>=2 and col>=2; latency pixel-in to window-out = 1 cycle.
REQ-017 SHALL produce exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per complete frame; no border padding.
REQ-018 SHALL, on a cycle with pix_valid=0, hold counters, buffers and p0..p8 unchanged and drive win_valid=0 next cycle.
REQ-019 SHALL never present a window spanning two lines (col<2 suppresses win_valid) nor two frames (row<2 suppresses win_valid).
REQ-020 SHALL treat sof arriving mid-frame as abort: counters restart; stale line-buffer contents are not exposed because row<2 gates win_valid.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, clear col, row, window registers, p0..p8 to 0 and win_valid to 0; pix_valid ignored.
REQ-022 SHALL NOT require clearing line-buffer RAM on reset; correctness relies on REQ-019.
REQ-023 SHALL, after rst deasserts, treat the first accepted pixel as (0,0) even without sof.

Configuration
REQ-024 SHALL, when macro SOBEL_LINEBUF_EOF_EN is defined, add output eof (1 bit, reset 0) pulsing high with the win_valid of the last window of a frame (pixel row IMG_H-1, col IMG_W-1).
REQ-025 SHALL, without SOBEL_LINEBUF_EOF_EN, omit port eof; all other behaviour identical.

Verification
REQ-026 SHALL cover: IMG_W=4, IMG_H=4, pixels 0..15 continuous with sof on first -> 4 win_valid pulses; first window p0=0,p1=1,p2=2,p3=4,p5=6,p6=8,p7=9,p8=10.
REQ-027 SHALL cover: same frame with pix_valid low every other cycle -> identical 4 windows, win_valid never high in a cycle not following an accepted pixel.
REQ-028 SHALL cover: IMG_W=8, IMG_H=8, two back-to-back frames -> 36 windows each; frame 2 first window p0 = frame 2 pixel (0,0).
REQ-029 SHALL cover: sof reasserted at pixel 20 of an 8x8 frame -> no win_valid until 18th pixel after restart (row 2, col 2).
REQ-030 SHALL cover: rst pulsed mid-frame -> next cycle all outputs 0, win_valid 0; following 64 pixels yield 36 windows.
REQ-031 SHALL cover: with SOBEL_LINEBUF_EOF_EN, 4x4 frame -> eof high only with 4th win_valid (p8=15).
